// File: rtl/alu_cmd_decoder.sv
// Decode stage ahead of the ALU: MIPS instruction -> ALU cmd plus execute/memory control bits,
// held in a 2-entry valid/ready FIFO with synchronous flush.
module alu_cmd_decoder #(
  parameter int INSTR_W = 32,
  parameter int CMD_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CMD_W-1:0]   alu_cmd,
  output logic               imm_sel,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_en,
  output logic               branch,
  output logic               illegal,
  output logic [1:0]         count
);

  localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(4'b0000);
  localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(4'b0010);
  localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(4'b0100);
  localparam logic [CMD_W-1:0] CMD_OR  = CMD_W'(4'b0101);
  localparam logic [CMD_W-1:0] CMD_NOR = CMD_W'(4'b0110);
  localparam logic [CMD_W-1:0] CMD_XOR = CMD_W'(4'b0111);
  localparam logic [CMD_W-1:0] CMD_SLL = CMD_W'(4'b1000);
  localparam logic [CMD_W-1:0] CMD_SRA = CMD_W'(4'b1001);
  localparam logic [CMD_W-1:0] CMD_SRL = CMD_W'(4'b1010);

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic             imm_sel;
    logic             mem_read;
    logic             mem_write;
    logic             wb_en;
    logic             branch;
    logic             illegal;
  } entry_t;

  entry_t     dec;
  entry_t     head;
  entry_t     mem [2];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [5:0] op;
  logic [5:0] funct;
  logic       accept;
  logic       pop;
  logic       unused_instr;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];

  always_comb begin
    dec = '0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: dec.cmd = CMD_ADD;
          6'b100010: dec.cmd = CMD_SUB;
          6'b100100: dec.cmd = CMD_AND;
          6'b100101: dec.cmd = CMD_OR;
          6'b100111: dec.cmd = CMD_NOR;
          6'b100110: dec.cmd = CMD_XOR;
          6'b000000: dec.cmd = CMD_SLL;
          6'b000011: dec.cmd = CMD_SRA;
          6'b000010: dec.cmd = CMD_SRL;
          default:   dec.illegal = 1'b1;
        endcase
        dec.wb_en = !dec.illegal;
      end
      6'b001000: begin dec.cmd = CMD_ADD; dec.imm_sel = 1'b1; dec.wb_en = 1'b1; end
      6'b001100: begin dec.cmd = CMD_AND; dec.imm_sel = 1'b1; dec.wb_en = 1'b1; end
      6'b001101: begin dec.cmd = CMD_OR;  dec.imm_sel = 1'b1; dec.wb_en = 1'b1; end
      6'b001110: begin dec.cmd = CMD_XOR; dec.imm_sel = 1'b1; dec.wb_en = 1'b1; end
      6'b100011: begin
        dec.cmd      = CMD_ADD;
        dec.imm_sel  = 1'b1;
        dec.mem_read = 1'b1;
        dec.wb_en    = 1'b1;
      end
      6'b101011: begin dec.cmd = CMD_ADD; dec.imm_sel = 1'b1; dec.mem_write = 1'b1; end
      6'b000100,
      6'b000101: begin dec.cmd = CMD_SUB; dec.branch = 1'b1; end
      default:   dec.illegal = 1'b1;
    endcase
  end

  // Pointers carry a wrap bit, so their difference is the occupancy 0..2.
  assign count     = wr_ptr - rd_ptr;
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr[0]] <= dec;
        wr_ptr         <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
    end
  end

  assign head      = out_valid ? mem[rd_ptr[0]] : '0;
  assign alu_cmd   = head.cmd;
  assign imm_sel   = head.imm_sel;
  assign mem_read  = head.mem_read;
  assign mem_write = head.mem_write;
  assign wb_en     = head.wb_en;
  assign branch    = head.branch;
  assign illegal   = head.illegal;

endmodule

// File: tb/tb_alu_cmd_decoder.sv
// Directed self-checking bench for alu_cmd_decoder using immediate assertions.
module tb_alu_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [31:0] instr;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_cmd;
  logic       imm_sel, mem_read, mem_write, wb_en, branch, illegal;
  logic [1:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_cmd_decoder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_cmd(alu_cmd), .imm_sel(imm_sel), .mem_read(mem_read),
    .mem_write(mem_write), .wb_en(wb_en), .branch(branch),
    .illegal(illegal), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {6'd0, 5'd9, 5'd10, 5'd8, 5'd2, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o);
    return {o, 5'd9, 5'd8, 16'h0004};
  endfunction

  // ctrl packing: {imm_sel, mem_read, mem_write, wb_en, branch, illegal}
  function automatic logic [5:0] ctrl();
    return {imm_sel, mem_read, mem_write, wb_en, branch, illegal};
  endfunction

  logic [31:0] vec_i [12];
  logic [3:0]  vec_c [12];
  logic [5:0]  vec_f [12];

  initial begin
    vec_i[0]  = rtype(6'b100010); vec_c[0]  = 4'b0010; vec_f[0]  = 6'b000100;
    vec_i[1]  = rtype(6'b100100); vec_c[1]  = 4'b0100; vec_f[1]  = 6'b000100;
    vec_i[2]  = rtype(6'b100101); vec_c[2]  = 4'b0101; vec_f[2]  = 6'b000100;
    vec_i[3]  = rtype(6'b100111); vec_c[3]  = 4'b0110; vec_f[3]  = 6'b000100;
    vec_i[4]  = rtype(6'b100110); vec_c[4]  = 4'b0111; vec_f[4]  = 6'b000100;
    vec_i[5]  = rtype(6'b000000); vec_c[5]  = 4'b1000; vec_f[5]  = 6'b000100;
    vec_i[6]  = rtype(6'b000011); vec_c[6]  = 4'b1001; vec_f[6]  = 6'b000100;
    vec_i[7]  = rtype(6'b000010); vec_c[7]  = 4'b1010; vec_f[7]  = 6'b000100;
    vec_i[8]  = itype(6'b001000); vec_c[8]  = 4'b0000; vec_f[8]  = 6'b100100;
    vec_i[9]  = itype(6'b100011); vec_c[9]  = 4'b0000; vec_f[9]  = 6'b110100;
    vec_i[10] = itype(6'b101011); vec_c[10] = 4'b0000; vec_f[10] = 6'b101000;
    vec_i[11] = itype(6'b000100); vec_c[11] = 4'b0010; vec_f[11] = 6'b000010;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    repeat (2) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_alu_cmd", alu_cmd, 0);
    chk("rst_ctrl", ctrl(), 0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // add, single entry
    in_valid = 1'b1; instr = 32'h012A4020; out_ready = 1'b1;
    step();
    chk("add_out_valid", out_valid, 1);
    chk("add_cmd", alu_cmd, 4'b0000);
    chk("add_ctrl", ctrl(), 6'b000100);
    chk("add_count", count, 1);

    // back-to-back stream: accept and pop every cycle, occupancy stays 1
    for (int i = 0; i < 12; i++) begin
      instr = vec_i[i];
      step();
      chk($sformatf("stream%0d_valid", i), out_valid, 1);
      chk($sformatf("stream%0d_cmd", i), alu_cmd, vec_c[i]);
      chk($sformatf("stream%0d_ctrl", i), ctrl(), vec_f[i]);
      chk($sformatf("stream%0d_count", i), count, 1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_zero_cmd", alu_cmd, 0);
    chk("drain_zero_ctrl", ctrl(), 0);

    // fill to full with execute stalled
    out_ready = 1'b0; in_valid = 1'b1; instr = rtype(6'b100100);
    step();
    chk("fill1_count", count, 1);
    instr = rtype(6'b100101);
    step();
    chk("fill2_count", count, 2);
    chk("full_in_ready", in_ready, 0);
    instr = rtype(6'b100110);
    step();
    chk("full_hold_count", count, 2);
    chk("full_hold_cmd", alu_cmd, 4'b0100);
    // full with out_ready=1: xor still refused, only a pop happens
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("full_pop_count", count, 1);
    chk("full_pop_cmd", alu_cmd, 4'b0101);
    step();
    chk("full_drain_count", count, 0);
    chk("full_drain_valid", out_valid, 0);

    // count=1 with simultaneous accept and pop
    out_ready = 1'b0; in_valid = 1'b1; instr = rtype(6'b100111);
    step();
    chk("sim_pre_cmd", alu_cmd, 4'b0110);
    out_ready = 1'b1; instr = rtype(6'b000010);
    step();
    chk("sim_count", count, 1);
    chk("sim_cmd", alu_cmd, 4'b1010);
    in_valid = 1'b0;
    step();
    chk("sim_drain_count", count, 0);

    // flush while full with a concurrent accept and pop
    out_ready = 1'b0; in_valid = 1'b1; instr = itype(6'b001000);
    step();
    instr = itype(6'b001101);
    step();
    chk("preflush_count", count, 2);
    flush = 1'b1; out_ready = 1'b1; instr = itype(6'b001110);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    step();
    chk("flush_after_count", count, 0);

    // illegal encodings, then async reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFC000000;
    step();
    chk("ill_valid", out_valid, 1);
    chk("ill_cmd", alu_cmd, 0);
    chk("ill_ctrl", ctrl(), 6'b000001);
    instr = rtype(6'b101010);
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("ill2_count", count, 2);
    step();
    chk("ill_rfunct_cmd", alu_cmd, 0);
    chk("ill_rfunct_ctrl", ctrl(), 6'b000001);
    out_ready = 1'b0; in_valid = 1'b1; instr = itype(6'b101011);
    step();
    in_valid = 1'b0;
    chk("prerst_count", count, 2);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_ctrl", ctrl(), 0);
    #2 rst = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
